// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared constants and CDB packet type for the complete stage
//
// Purpose: machine-wide sizes used by the FU/CDB arbiter and its picker,
// plus the packet carried on one CDB lane.
// Ports: none (package).

package sys_defs;

  localparam int NUM_FU    = 4;
  localparam int CDB_WIDTH = 2;
  localparam int XLEN      = 32;
  localparam int TAG_W     = 5;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  npc;
    logic             branch_taken;
  } CDB_PACKET;

  // Pointer width that stays legal for a single-source configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// rtl/cdb_rr_picker.sv - combinational round-robin multi-grant picker
//
// Purpose: scans req starting at rr_ptr (wrapping modulo NUM_FU) and grants
// the first CDB_WIDTH requesters in scan order.
// Ports:
//   req       in   NUM_FU               full-slot request vector
//   rr_ptr    in   PTR_W                first index scanned
//   grant     out  NUM_FU               granted requesters
//   lane_sel  out  CDB_WIDTH x NUM_FU   one-hot source for each lane
//   next_ptr  out  PTR_W                last granted index + 1 (mod NUM_FU)

module cdb_rr_picker #(
  parameter int NUM_FU    = sys_defs::NUM_FU,
  parameter int CDB_WIDTH = sys_defs::CDB_WIDTH,
  parameter int PTR_W     = sys_defs::ptr_width(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                 req,
  input  logic [PTR_W-1:0]                  rr_ptr,
  output logic [NUM_FU-1:0]                 grant,
  output logic [CDB_WIDTH-1:0][NUM_FU-1:0]  lane_sel,
  output logic [PTR_W-1:0]                  next_ptr
);

  always_comb begin
    int cnt;
    int idx;
    grant    = '0;
    lane_sel = '0;
    next_ptr = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int s = 0; s < NUM_FU; s++) begin
      // rr_ptr < NUM_FU, so a single subtraction completes the modulo.
      idx = int'(rr_ptr) + s;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
        if (idx == i && req[i] && cnt < CDB_WIDTH) begin
          grant[i] = 1'b1;
          for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cnt == k) lane_sel[k][i] = 1'b1;
          end
          cnt      = cnt + 1;
          next_ptr = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// rtl/fu_cdb_arbiter.sv - FU result holding slots and round-robin CDB broadcast
//
// Purpose: each FU result lands in a one-entry slot; up to CDB_WIDTH full
// slots are broadcast per cycle, and full ungranted slots stall their FU.
// Ports:
//   clock, reset                 clock, async active-high reset
//   clear                        synchronous squash of all slots
//   fu_valid/tag/result/npc/branch_taken   per-FU result inputs (flattened)
//   fu_stall                     per-FU hold request
//   cdb_valid/tag/result/npc/branch_taken  per-lane broadcast (flattened)

module fu_cdb_arbiter #(
  parameter int NUM_FU    = sys_defs::NUM_FU,
  parameter int CDB_WIDTH = sys_defs::CDB_WIDTH,
  parameter int XLEN      = sys_defs::XLEN,
  parameter int TAG_W     = sys_defs::TAG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*XLEN-1:0]     fu_result,
  input  logic [NUM_FU*XLEN-1:0]     fu_npc,
  input  logic [NUM_FU-1:0]          fu_branch_taken,
  output logic [NUM_FU-1:0]          fu_stall,
  output logic [CDB_WIDTH-1:0]       cdb_valid,
  output logic [CDB_WIDTH*TAG_W-1:0] cdb_tag,
  output logic [CDB_WIDTH*XLEN-1:0]  cdb_result,
  output logic [CDB_WIDTH*XLEN-1:0]  cdb_npc,
  output logic [CDB_WIDTH-1:0]       cdb_branch_taken
);

  localparam int PTR_W = sys_defs::ptr_width(NUM_FU);

  logic [NUM_FU-1:0]                slot_full;
  logic [TAG_W-1:0]                 slot_tag    [NUM_FU];
  logic [XLEN-1:0]                  slot_result [NUM_FU];
  logic [XLEN-1:0]                  slot_npc    [NUM_FU];
  logic [NUM_FU-1:0]                slot_taken;
  logic [PTR_W-1:0]                 rr_ptr;

  logic [NUM_FU-1:0]                grant_raw;
  logic [NUM_FU-1:0]                grant;
  logic [CDB_WIDTH-1:0][NUM_FU-1:0] lane_sel;
  logic [PTR_W-1:0]                 next_ptr;
  sys_defs::CDB_PACKET              lane [CDB_WIDTH];

  cdb_rr_picker #(
    .NUM_FU    (NUM_FU),
    .CDB_WIDTH (CDB_WIDTH),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req      (slot_full),
    .rr_ptr   (rr_ptr),
    .grant    (grant_raw),
    .lane_sel (lane_sel),
    .next_ptr (next_ptr)
  );

  // A squash cycle broadcasts nothing and releases every stall.
  assign grant    = clear ? '0 : grant_raw;
  assign fu_stall = slot_full & ~grant & {NUM_FU{~clear}};

  // Lane k is the OR of its one-hot selected slot; empty lanes read as zero.
  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      lane[k] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (lane_sel[k][i] && !clear) begin
          lane[k].valid        = 1'b1;
          lane[k].tag          = slot_tag[i];
          lane[k].result       = slot_result[i];
          lane[k].npc          = slot_npc[i];
          lane[k].branch_taken = slot_taken[i];
        end
      end
    end
  end

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
    assign cdb_valid[k]                 = lane[k].valid;
    assign cdb_tag[k*TAG_W +: TAG_W]    = lane[k].tag;
    assign cdb_result[k*XLEN +: XLEN]   = lane[k].result;
    assign cdb_npc[k*XLEN +: XLEN]      = lane[k].npc;
    assign cdb_branch_taken[k]          = lane[k].branch_taken;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_full  <= '0;
      slot_taken <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_tag[i]    <= '0;
        slot_result[i] <= '0;
        slot_npc[i]    <= '0;
      end
    end else if (clear) begin
      slot_full <= '0;
      rr_ptr    <= '0;
    end else begin
      if (|grant_raw) rr_ptr <= next_ptr;
      for (int i = 0; i < NUM_FU; i++) begin
        // Capture wins over free so a granted slot refills in the same edge.
        if (fu_valid[i] && !fu_stall[i]) begin
          slot_full[i]   <= 1'b1;
          slot_tag[i]    <= fu_tag[i*TAG_W +: TAG_W];
          slot_result[i] <= fu_result[i*XLEN +: XLEN];
          slot_npc[i]    <= fu_npc[i*XLEN +: XLEN];
          slot_taken[i]  <= fu_branch_taken[i];
        end else if (grant[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// tb/tb_fu_cdb_arbiter.sv - directed self-checking bench for fu_cdb_arbiter

module tb_fu_cdb_arbiter;

  localparam int NF = 4;
  localparam int CW = 2;
  localparam int XL = 32;
  localparam int TW = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic [NF-1:0]     fu_valid = '0;
  logic [NF*TW-1:0]  fu_tag = '0;
  logic [NF*XL-1:0]  fu_result = '0;
  logic [NF*XL-1:0]  fu_npc = '0;
  logic [NF-1:0]     fu_branch_taken = '0;
  logic [NF-1:0]     fu_stall;
  logic [CW-1:0]     cdb_valid;
  logic [CW*TW-1:0]  cdb_tag;
  logic [CW*XL-1:0]  cdb_result;
  logic [CW*XL-1:0]  cdb_npc;
  logic [CW-1:0]     cdb_branch_taken;

  int checks = 0;
  int failures = 0;

  fu_cdb_arbiter #(.NUM_FU(NF), .CDB_WIDTH(CW), .XLEN(XL), .TAG_W(TW)) dut (
    .clock            (clock),
    .reset            (reset),
    .clear            (clear),
    .fu_valid         (fu_valid),
    .fu_tag           (fu_tag),
    .fu_result        (fu_result),
    .fu_npc           (fu_npc),
    .fu_branch_taken  (fu_branch_taken),
    .fu_stall         (fu_stall),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_result       (cdb_result),
    .cdb_npc          (cdb_npc),
    .cdb_branch_taken (cdb_branch_taken)
  );

  always #5 clock = ~clock;

  function automatic logic [TW-1:0] ltag(input int k);
    return cdb_tag[k*TW +: TW];
  endfunction

  function automatic logic [XL-1:0] lres(input int k);
    return cdb_result[k*XL +: XL];
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [XL-1:0] r,
                        input logic [XL-1:0] n, input logic b);
    fu_tag[i*TW +: TW]    = t;
    fu_result[i*XL +: XL] = r;
    fu_npc[i*XL +: XL]    = n;
    fu_branch_taken[i]    = b;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear = 1'b0;
    fu_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_result, cdb_npc, cdb_branch_taken, fu_stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b tag=%h stall=%b required all zero", cdb_valid, cdb_tag, fu_stall);
    end
    do_reset;
    for (int c = 0; c < 10; c++) begin
      step;
      checks++;
      if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
        failures++;
        $display("FAIL idle_cycle%0d got valid=%b stall=%b required 00/0000", c, cdb_valid, fu_stall);
      end
    end
  endtask

  task automatic test_single;
    do_reset;
    step;
    set_fu(1, 5'd5, 32'h1234, 32'h4004, 1'b1);
    fu_valid = 4'b0010;
    step;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b01 || ltag(0) !== 5'd5 || lres(0) !== 32'h1234 ||
        cdb_npc[31:0] !== 32'h4004 || cdb_branch_taken !== 2'b01) begin
      failures++;
      $display("FAIL single_lane0 got valid=%b tag=%0d res=%h npc=%h bt=%b required 01/5/1234/4004/01",
               cdb_valid, ltag(0), lres(0), cdb_npc[31:0], cdb_branch_taken);
    end
    checks++;
    if (ltag(1) !== 5'd0 || lres(1) !== 32'h0 || cdb_npc[63:32] !== 32'h0) begin
      failures++;
      $display("FAIL single_lane1_zero got tag=%0d res=%h required 0/0", ltag(1), lres(1));
    end
    step;
    checks++;
    if (cdb_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_drain got valid=%b required 00", cdb_valid);
    end
  endtask

  task automatic test_all_four;
    do_reset;
    step;
    for (int i = 0; i < NF; i++) set_fu(i, TW'(10 + i), XL'(32'hA0 + i), XL'(32'h100 + 4 * i), i[0]);
    fu_valid = 4'b1111;
    step;
    fu_valid = 4'b1100;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || ltag(0) !== 5'd10 || ltag(1) !== 5'd11 || fu_stall !== 4'b1100 ||
        lres(0) !== 32'hA0 || lres(1) !== 32'hA1 || cdb_branch_taken !== 2'b10) begin
      failures++;
      $display("FAIL all4_c1 got valid=%b tags=%0d,%0d stall=%b bt=%b required 11 10,11 1100 10",
               cdb_valid, ltag(0), ltag(1), fu_stall, cdb_branch_taken);
    end
    step;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || ltag(0) !== 5'd12 || ltag(1) !== 5'd13 || fu_stall !== 4'b0000 ||
        lres(0) !== 32'hA2 || cdb_npc[63:32] !== 32'h10C || cdb_branch_taken !== 2'b10) begin
      failures++;
      $display("FAIL all4_c2 got valid=%b tags=%0d,%0d stall=%b npc1=%h required 11 12,13 0000 10c",
               cdb_valid, ltag(0), ltag(1), fu_stall, cdb_npc[63:32]);
    end
    step;
    checks++;
    if (cdb_valid !== 2'b00) begin
      failures++;
      $display("FAIL all4_drain got valid=%b required 00", cdb_valid);
    end
    // Pointer wrapped to 0: FU0 must lead FU3.
    set_fu(0, 5'd20, 32'hB0, 32'h200, 1'b0);
    set_fu(3, 5'd23, 32'hB3, 32'h20C, 1'b0);
    fu_valid = 4'b1001;
    step;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || ltag(0) !== 5'd20 || ltag(1) !== 5'd23) begin
      failures++;
      $display("FAIL all4_wrap got valid=%b tags=%0d,%0d required 11 20,23", cdb_valid, ltag(0), ltag(1));
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    step;
    set_fu(2, 5'd1, 32'h11, 32'h300, 1'b0);
    fu_valid = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      step;
      if (c < 3) set_fu(2, TW'(c + 1), XL'(32'h10 + c + 1), 32'h300, 1'b0);
      else fu_valid = 4'b0000;
      #1;
      checks++;
      if (cdb_valid !== 2'b01 || ltag(0) !== TW'(c) || fu_stall[2] !== 1'b0 || lres(0) !== XL'(32'h10 + c)) begin
        failures++;
        $display("FAIL stream_c%0d got valid=%b tag=%0d stall=%b required 01 %0d 0", c, cdb_valid, ltag(0), fu_stall, c);
      end
    end
    step;
    checks++;
    if (cdb_valid !== 2'b00) begin
      failures++;
      $display("FAIL stream_drain got valid=%b required 00", cdb_valid);
    end
  endtask

  task automatic test_clear;
    do_reset;
    step;
    set_fu(0, 5'd7, 32'h70, 32'h400, 1'b0);
    fu_valid = 4'b0001;
    step;
    for (int i = 0; i < NF; i++) set_fu(i, TW'(16 + i), XL'(32'hC0 + i), 32'h500, 1'b0);
    fu_valid = 4'b1111;
    #1;
    checks++;
    if (cdb_valid !== 2'b01 || ltag(0) !== 5'd7) begin
      failures++;
      $display("FAIL clear_setup got valid=%b tag=%0d required 01 7", cdb_valid, ltag(0));
    end
    step;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || ltag(0) !== 5'd17 || ltag(1) !== 5'd18 || fu_stall !== 4'b1001) begin
      failures++;
      $display("FAIL clear_pre got valid=%b tags=%0d,%0d stall=%b required 11 17,18 1001",
               cdb_valid, ltag(0), ltag(1), fu_stall);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
      failures++;
      $display("FAIL clear_cycle got valid=%b stall=%b required 00 0000", cdb_valid, fu_stall);
    end
    step;
    clear = 1'b0;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
      failures++;
      $display("FAIL clear_after got valid=%b stall=%b required 00 0000", cdb_valid, fu_stall);
    end
    // Pointer back at 0: FU0 must lead FU3.
    set_fu(0, 5'd21, 32'hD0, 32'h600, 1'b1);
    set_fu(3, 5'd24, 32'hD3, 32'h60C, 1'b0);
    fu_valid = 4'b1001;
    step;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || ltag(0) !== 5'd21 || ltag(1) !== 5'd24 || cdb_branch_taken !== 2'b01) begin
      failures++;
      $display("FAIL clear_ptr got valid=%b tags=%0d,%0d bt=%b required 11 21,24 01",
               cdb_valid, ltag(0), ltag(1), cdb_branch_taken);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    step;
    for (int i = 0; i < 3; i++) set_fu(i, TW'(1 + i), XL'(32'hE0 + i), 32'h700, 1'b1);
    fu_valid = 4'b0111;
    step;
    fu_valid = 4'b0100;
    #1;
    checks++;
    if (cdb_valid !== 2'b11 || fu_stall !== 4'b0100) begin
      failures++;
      $display("FAIL areset_pre got valid=%b stall=%b required 11 0100", cdb_valid, fu_stall);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_result, cdb_npc, cdb_branch_taken, fu_stall} !== '0) begin
      failures++;
      $display("FAIL areset_immediate got valid=%b tag=%h stall=%b required all zero", cdb_valid, cdb_tag, fu_stall);
    end
    fu_valid = 4'b0000;
    step;
    reset = 1'b0;
    step;
    checks++;
    if (cdb_valid !== 2'b00 || fu_stall !== 4'b0000) begin
      failures++;
      $display("FAIL areset_lost got valid=%b stall=%b required 00 0000", cdb_valid, fu_stall);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_four;
    test_back_to_back;
    test_clear;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
